// File: rtl/dtcm_ctrl_pkg.sv
// Shared widths and response-kind type for the LSU-to-DTCM responder.
package dtcm_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 16;

  typedef enum logic {
    RSP_WRITE = 1'b0,
    RSP_READ  = 1'b1
  } rsp_kind_e;

endpackage

// File: rtl/dtcm_ctrl_if.sv
// LSU-to-DTCM command/response channel; the LSU is master, the DTCM controller is slave.
interface dtcm_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 16
);

  logic            dtcm_cmd_valid;
  logic            dtcm_cmd_ready;
  logic            dtcm_cmd_read;
  logic [AW-1:0]   dtcm_cmd_addr;
  logic [DW-1:0]   dtcm_cmd_wdata;
  logic [DW/8-1:0] dtcm_cmd_wmask;
  logic            dtcm_rsp_valid;
  logic            dtcm_rsp_ready;
  logic [DW-1:0]   dtcm_rsp_rdata;

  modport master (
    output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    output dtcm_rsp_ready,
    input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
  );

  modport slave (
    input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
    input  dtcm_rsp_ready,
    output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
  );

endinterface

// File: rtl/dtcm_sram.sv
// 1RW synchronous byte-maskable SRAM model; the only piece swapped for a technology macro.
module dtcm_sram #(
  parameter int DW    = 32,
  parameter int AW_W  = 14,
  parameter int DEPTH = 2**AW_W
) (
  input  logic            clk,
  input  logic            cs,
  input  logic            we,
  input  logic [DW/8-1:0] wem,
  input  logic [AW_W-1:0] addr,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout
);

  // NOTE: storage has no reset; a real macro cannot clear its array and reads of
  // unwritten words are undefined by design.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (wem[i]) r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end else begin
        dout <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM responder: accepts one command per cycle, returns one response a cycle later,
// and holds that response (via hold register) until the LSU consumes it.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW    = XLEN,
  parameter int AW    = DTCM_ADDR_WIDTH,
  parameter int DEPTH = 2**(AW-2)
) (
  input  logic        clk,
  input  logic        rst,
  dtcm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RSP  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e        r_state;
  rsp_kind_e     r_rsp_kind;
  logic [DW-1:0] r_hold_q;

  logic          w_rsp_vld;
  logic          w_cmd_hsk;
  logic          w_sram_cs;
  logic [DW-1:0] w_sram_dout;
  logic          w_unused_addr_lsb;

  assign w_rsp_vld          = (r_state != S_IDLE);
  assign bus.dtcm_cmd_ready = ~w_rsp_vld | bus.dtcm_rsp_ready;
  assign w_cmd_hsk          = bus.dtcm_cmd_valid & bus.dtcm_cmd_ready;
  // A command coinciding with reset must not reach the array.
  assign w_sram_cs          = w_cmd_hsk & ~rst;
  assign w_unused_addr_lsb  = ^bus.dtcm_cmd_addr[1:0];

  dtcm_sram #(
    .DW    (DW),
    .AW_W  (AW-2),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk  (clk),
    .cs   (w_sram_cs),
    .we   (~bus.dtcm_cmd_read),
    .wem  (bus.dtcm_cmd_wmask),
    .addr (bus.dtcm_cmd_addr[AW-1:2]),
    .din  (bus.dtcm_cmd_wdata),
    .dout (w_sram_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rsp_kind <= RSP_WRITE;
      r_hold_q   <= '0;
    end else begin
      if (w_cmd_hsk) r_rsp_kind <= bus.dtcm_cmd_read ? RSP_READ : RSP_WRITE;
      unique case (r_state)
        S_IDLE: if (w_cmd_hsk) r_state <= S_RSP;
        S_RSP: begin
          if (bus.dtcm_rsp_ready) begin
            r_state <= w_cmd_hsk ? S_RSP : S_IDLE;
          end else begin
            // Freeze the SRAM output so the stalled response survives later reads.
            r_state  <= S_HOLD;
            r_hold_q <= w_sram_dout;
          end
        end
        S_HOLD: if (bus.dtcm_rsp_ready) r_state <= w_cmd_hsk ? S_RSP : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dtcm_rsp_valid = w_rsp_vld;

  always_comb begin
    bus.dtcm_rsp_rdata = '0;
    if (w_rsp_vld && r_rsp_kind == RSP_READ) begin
      bus.dtcm_rsp_rdata = (r_state == S_HOLD) ? r_hold_q : w_sram_dout;
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed bench for dtcm_ctrl: stimulus pushes hand-computed responses into a
// scoreboard queue, a negedge monitor pops and compares on each response handshake.
module tb_dtcm_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    int            issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   pending_seen = 1'b0;
  int   first_seen = 0;

  dtcm_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  dtcm_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One bus cycle: drive after the edge, then record an accepted command.
  task automatic drive(input bit v, input bit rd, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input bit rr, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    bus.dtcm_cmd_valid = v;
    bus.dtcm_cmd_read  = rd;
    bus.dtcm_cmd_addr  = a;
    bus.dtcm_cmd_wdata = wd;
    bus.dtcm_cmd_wmask = wm;
    bus.dtcm_rsp_ready = rr;
    #1;
    if (v && bus.dtcm_cmd_ready && !rst) exp_q.push_back('{rdata: exp_rd, issue: cyc});
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] wm);
    drive(1'b1, 1'b0, a, wd, wm, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp_rd);
    drive(1'b1, 1'b1, a, 32'h0, 4'h0, 1'b1, exp_rd);
  endtask

  task automatic idle(input bit rr);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, rr, 32'h0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rsp_valid"}, {31'h0, bus.dtcm_rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata"}, bus.dtcm_rsp_rdata, 32'h0);
    check({tag, "_cmd_ready"}, {31'h0, bus.dtcm_cmd_ready}, 32'h1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      pending_seen = 1'b0;
    end else if (cyc > 1) begin
      if (!bus.dtcm_rsp_valid) begin
        check("rdata_zero_when_invalid", bus.dtcm_rsp_rdata, 32'h0);
      end else begin
        if (!pending_seen) begin
          pending_seen = 1'b1;
          first_seen   = cyc;
        end
        if (bus.dtcm_rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: response with rdata 0x%08h, expected none (cycle %0d)",
                     bus.dtcm_rsp_rdata, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_rdata", bus.dtcm_rsp_rdata, e.rdata);
            check("rsp_latency", 32'(first_seen), 32'(e.issue + 1));
          end
          pending_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_cmd_read  = 1'b0;
    bus.dtcm_cmd_addr  = '0;
    bus.dtcm_cmd_wdata = '0;
    bus.dtcm_cmd_wmask = '0;
    bus.dtcm_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle("reset");

    // Full write, read-after-write, masked write.
    wr(16'h0010, 32'hDEADBEEF, 4'hF);
    rd(16'h0010, 32'hDEADBEEF);
    wr(16'h0010, 32'h11223344, 4'b0101);
    rd(16'h0010, 32'hDE22BE44);
    wr(16'h0010, 32'hDEADBEEF, 4'hF);

    // Back-to-back reads at full throughput.
    wr(16'h0000, 32'h00000011, 4'hF);
    wr(16'h0004, 32'h22220000, 4'hF);
    wr(16'h0008, 32'h12345678, 4'hF);
    rd(16'h0000, 32'h00000011);
    check("b2b_cmd_ready0", {31'h0, bus.dtcm_cmd_ready}, 32'h1);
    rd(16'h0004, 32'h22220000);
    check("b2b_cmd_ready1", {31'h0, bus.dtcm_cmd_ready}, 32'h1);
    rd(16'h0008, 32'h12345678);
    check("b2b_cmd_ready2", {31'h0, bus.dtcm_cmd_ready}, 32'h1);
    idle(1'b1);

    // Stall the read response with a write waiting behind it.
    rd(16'h0010, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h55555555, 4'hF, 1'b0, 32'h0);
      check("hold_cmd_ready", {31'h0, bus.dtcm_cmd_ready}, 32'h0);
      check("hold_rsp_valid", {31'h0, bus.dtcm_rsp_valid}, 32'h1);
      check("hold_rsp_rdata", bus.dtcm_rsp_rdata, 32'hDEADBEEF);
    end
    drive(1'b1, 1'b0, 16'h0010, 32'h55555555, 4'hF, 1'b1, 32'h0);
    check("release_cmd_ready", {31'h0, bus.dtcm_cmd_ready}, 32'h1);
    rd(16'h0010, 32'h55555555);

    // Reset while holding, with a write offered in the reset cycle.
    rd(16'h0010, 32'h55555555);
    drive(1'b1, 1'b0, 16'h0010, 32'h99999999, 4'hF, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 16'h0010, 32'h99999999, 4'hF, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.dtcm_rsp_ready = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_rsp_ready = 1'b0;
    #1;
    check_idle("mid_reset");
    rd(16'h0010, 32'h55555555);

    // Zero-mask write is a responded no-op.
    wr(16'h0008, 32'hFFFFFFFF, 4'h0);
    rd(16'h0008, 32'h12345678);

    repeat (3) idle(1'b1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtcm_ctrl.md
# dtcm_ctrl

Responder end of the LSU→DTCM command/response interface. Accepts one read or write command per cycle from the LSU control unit and drives a single-port, byte-maskable SRAM. Returns exactly one response per accepted command, one cycle after acceptance, and holds it until the LSU accepts it. Sits between the LSU and the data tightly-coupled memory macro.

## Interface
Parameters:
- DW, `XLEN (32): data width; must be 32.
- AW, `DTCM_ADDR_WIDTH (16): byte-address width.
- DEPTH, 2**(AW-2) (16384): number of SRAM words.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dtcm_cmd_valid  in  1  command valid.
- dtcm_cmd_ready  out  1  command accepted this cycle when high together with valid.
- dtcm_cmd_read  in  1  1 = read, 0 = write.
- dtcm_cmd_addr  in  AW  byte address; bits [1:0] ignored.
- dtcm_cmd_wdata  in  DW  write data, already lane-aligned by the AGU.
- dtcm_cmd_wmask  in  DW/8  byte-lane write enables; ignored for reads.
- dtcm_rsp_valid  out  1  response valid.
- dtcm_rsp_ready  in  1  response consumed when high together with valid.
- dtcm_rsp_rdata  out  DW  read data; 0 for write responses and whenever rsp_valid is 0.

## Operation
- Command handshake: cmd_hsk = dtcm_cmd_valid & dtcm_cmd_ready. Word index = dtcm_cmd_addr[AW-1:2].
- dtcm_cmd_ready = ~rsp_vld_q | dtcm_rsp_ready. A new command is accepted in the same cycle the pending response retires, giving a throughput of 1 command/cycle.
- On cmd_hsk with read=1: SRAM chip-select asserted, write-enable 0, and the response is marked as a read.
- On cmd_hsk with read=0: SRAM written only in the lanes with wmask[i]=1; other lanes are unchanged. The response is marked as a write. wmask=0 is a legal no-op write and still produces a response.
- FSM states (rsp_vld_q, rsp_hold_q):
  - IDLE: no response pending. cmd_hsk → RSP.
  - RSP: response valid. Read data comes directly from the SRAM output. rsp_ready & cmd_hsk → RSP (new response). rsp_ready & no cmd → IDLE. No rsp_ready → HOLD.
  - HOLD: response valid. Data comes from hold register hold_q, which captures the SRAM output on the RSP→HOLD transition. rsp_ready & cmd_hsk → RSP. rsp_ready only → IDLE. Otherwise stay in HOLD.
- dtcm_rsp_rdata = rsp_is_read ? (HOLD ? hold_q : sram_dout) : 0, gated by rsp_vld_q.
- The SRAM output register updates only on read cycles. Writes do not disturb sram_dout.
- Alignment and sign extension are not performed here; the LSU handles them.

## Timing
- Latency: command accepted in cycle N → dtcm_rsp_valid=1 in cycle N+1, for both reads and writes.
- Reset (rst=1 at an edge): rsp_vld_q=0, rsp_is_read=0, hold_q=0, state IDLE. Outputs next cycle: dtcm_rsp_valid=0, dtcm_rsp_rdata=0, dtcm_cmd_ready=1. SRAM contents are not reset.
- Reset mid-operation: any pending or held response is dropped. A command presented in the same cycle as rst=1 is not written to the SRAM (chip-select gated by ~rst).
- dtcm_cmd_ready has a combinational path from dtcm_rsp_ready. There is no combinational path from cmd inputs to rsp outputs.
- Read-after-write to the same word in consecutive cycles returns the newly written data.
- Response is held stable (valid, data) for every cycle rsp_ready=0.

## Structure
- Use the `XLEN and `DTCM_ADDR_WIDTH macros from defines.v. State encodings are localparams local to dtcm_ctrl (not shared).
- Sub-module dtcm_sram (parameters DW, AW_W=AW-2, DEPTH) is a 1RW synchronous SRAM behavioural model:
  - ports clk, cs, we, wem[DW/8-1:0], addr, din, dout.
  - dout registered on cs&~we only.
- The macro replacement for dtcm_sram is the only technology-dependent piece.

## Test plan
- Write 0xDEADBEEF with wmask=4'hF to addr 0x0010, then read 0x0010 → write rsp in cycle N+1 with rdata=0; read rsp rdata=0xDEADBEEF.
- Masked write 0x11223344 with wmask=4'b0101 to a word holding 0xDEADBEEF, then read → 0xDE22BE44.
- Back-to-back reads of 0x0, 0x4, 0x8 with rsp_ready=1 → cmd_ready stays 1, three responses on consecutive cycles, in order.
- Read 0x0010, then hold rsp_ready=0 for 3 cycles while a write to 0x0010 is presented → cmd_ready=0 for those 3 cycles, rdata stays 0xDEADBEEF, and the write is accepted in the cycle rsp_ready rises.
- Assert rst while in HOLD with a write pending on cmd → next cycle rsp_valid=0, rdata=0, cmd_ready=1; later read of the target word shows the old value.
- Write with wmask=0 → response returned, word unchanged on readback.
